// File: rtl/clock_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_pkg
// Description : Shared definitions for the programmable clock divider.
//               DEFAULT_WIDTH - default divisor / half-period counter width.
//               divisor_t     - divisor type at the default width.
// Options     : none (the CLOCK_DIVIDER_SAFE_LOAD_EN option lives in the top).
// Revision    : 1.0 - initial release
// ============================================================================
package clock_divider_pkg;

    // Default bit width of the divisor input and the half-period counter.
    localparam int unsigned DEFAULT_WIDTH = 24;

    // Divisor value at the default width (half-period length minus one).
    typedef logic [DEFAULT_WIDTH-1:0] divisor_t;

endpackage : clock_divider_pkg
`default_nettype wire

// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider
// Description : Programmable integer clock divider with a 50% duty-cycle,
//               fully registered output and a one-cycle rising-edge strobe.
//               f_out = f_clock / (2 * (divisor + 1)).
//
// Parameters  : WIDTH        - divisor / half-period counter width.
//
// Ports       : clock        in   system clock, rising-edge logic only
//               reset_n      in   asynchronous active-low reset
//               divisor      in   [WIDTH] half-period length minus one
//               output_clock out  divided clock, registered
//               rise_strobe  out  one-cycle pulse in the first cycle that
//                                 output_clock reads 1
//
// Options     : CLOCK_DIVIDER_SAFE_LOAD_EN
//                 defined   - divisor is sampled into a shadow register at
//                             each toggle point and in the first cycle after
//                             reset release; half-periods in progress keep
//                             their original length.
//                 undefined - the live divisor is compared every cycle.
//
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] divisor,
    output logic             output_clock,
    output logic             rise_strobe
);

    // ------------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_counter;
    logic             r_output_clock;
    logic             r_rise_strobe;

    logic [WIDTH-1:0] w_eff_divisor;
    logic             w_toggle;

`ifdef CLOCK_DIVIDER_SAFE_LOAD_EN
    // ------------------------------------------------------------------------
    // Shadow divisor. r_first marks the first cycle after reset release, where
    // the shadow still holds its reset value; the live divisor is used for
    // that one compare so the very first half-period already has the
    // requested length rather than a spurious length of one.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_shadow;
    logic             r_first;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
            r_first  <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (r_first || w_toggle) begin
                r_shadow <= divisor;
            end
        end
    end

    assign w_eff_divisor = r_first ? divisor : r_shadow;
`else
    assign w_eff_divisor = divisor;
`endif

    // ------------------------------------------------------------------------
    // Toggle point. The ">=" matters when the divisor is lowered below the
    // current count: the half-period ends on the next edge instead of the
    // counter running all the way round a 2^WIDTH wrap.
    // ------------------------------------------------------------------------
    assign w_toggle = (r_counter >= w_eff_divisor);

    // ------------------------------------------------------------------------
    // Counter, divided clock and strobe. The strobe is computed from the
    // same toggle decision so it rises in the same cycle as output_clock.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_counter      <= '0;
            r_output_clock <= 1'b0;
            r_rise_strobe  <= 1'b0;
        end else begin
            if (w_toggle) begin
                r_counter      <= '0;
                r_output_clock <= ~r_output_clock;
            end else begin
                r_counter      <= r_counter + 1'b1;
            end
            r_rise_strobe <= w_toggle & ~r_output_clock;
        end
    end

    assign output_clock = r_output_clock;
    assign rise_strobe  = r_rise_strobe;

endmodule : clock_divider
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_divider
// Description : Directed self-checking bench for clock_divider, built at
//               WIDTH=4 so the maximum divisor (15) is reachable quickly.
//               Expected waveforms come from the closed-form relation
//               output_clock after edge n = floor(n/(d+1)) mod 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider;

    localparam int unsigned TB_WIDTH = 4;

    logic                clock;
    logic                reset_n;
    logic [TB_WIDTH-1:0] divisor;
    logic                output_clock;
    logic                rise_strobe;

    int checks = 0;
    int errors = 0;

    clock_divider #(
        .WIDTH(TB_WIDTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .divisor     (divisor),
        .output_clock(output_clock),
        .rise_strobe (rise_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset, load the divisor, release on a falling edge so the next
    // rising edge is edge 1 of the new run.
    task automatic apply_reset(input int d);
        reset_n = 1'b0;
        divisor = TB_WIDTH'(d);
        @(negedge clock);
        chk($sformatf("rst_oc_d%0d", d), {31'd0, output_clock}, 32'd0);
        chk($sformatf("rst_rs_d%0d", d), {31'd0, rise_strobe}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Steady-divisor run of n edges from reset.
    task automatic run_div(input int d, input int n);
        int   ones;
        int   strobes;
        logic eo;
        logic es;
        apply_reset(d);
        ones    = 0;
        strobes = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            eo = ((i / (d + 1)) % 2) == 1;
            es = ((i % (d + 1)) == 0) && eo;
            chk($sformatf("d%0d_oc_e%0d", d, i), {31'd0, output_clock}, {31'd0, eo});
            chk($sformatf("d%0d_rs_e%0d", d, i), {31'd0, rise_strobe}, {31'd0, es});
            chk($sformatf("d%0d_cnt_e%0d", d, i),
                {31'd0, (int'(dut.r_counter) <= d)}, 32'd1);
            ones    += int'(output_clock);
            strobes += int'(rise_strobe);
        end
        chk($sformatf("d%0d_duty", d), ones, n / 2);
        chk($sformatf("d%0d_strobes", d), strobes, n / (2 * (d + 1)));
    endtask

    initial begin
        logic eo;
        reset_n = 1'b0;
        divisor = '0;

        // Reset held for three clocks.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_oc_%0d", i), {31'd0, output_clock}, 32'd0);
            chk($sformatf("hold_rs_%0d", i), {31'd0, rise_strobe}, 32'd0);
        end

        // Steady divisors, including the 4-bit maximum.
        run_div(0, 12);
        run_div(1, 16);
        run_div(2, 12);
        run_div(3, 16);
        run_div(15, 64);

        // Asynchronous reset mid-period: with d=1 edge 2 raises both outputs.
        apply_reset(1);
        tick();
        tick();
        chk("async_pre_oc", {31'd0, output_clock}, 32'd1);
        chk("async_pre_rs", {31'd0, rise_strobe}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_oc", {31'd0, output_clock}, 32'd0);
        chk("async_rs", {31'd0, rise_strobe}, 32'd0);

        // Live divisor change 5 -> 1 once the counter reaches 4.
        apply_reset(5);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("live_pre_oc_e%0d", i), {31'd0, output_clock}, 32'd0);
        end
        chk("live_cnt4", {28'd0, dut.r_counter}, 32'd4);
        divisor = 4'd1;
        for (int i = 5; i <= 14; i++) begin
            tick();
`ifdef CLOCK_DIVIDER_SAFE_LOAD_EN
            // Current half-period still lasts 6 clocks (toggle at edge 6).
            eo = (i >= 6) && ((((i - 4) / 2) % 2) == 1);
`else
            // Toggle on edge 5, then steady f/4.
            eo = (((i - 3) / 2) % 2) == 1;
`endif
            chk($sformatf("live_oc_e%0d", i), {31'd0, output_clock}, {31'd0, eo});
            chk($sformatf("live_cnt_e%0d", i), {31'd0, (dut.r_counter <= 4'd5)}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_clock_divider
`default_nettype wire

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Programmable integer clock divider that produces a 50% duty-cycle divided clock from the single system clock.
- The divide ratio is set by a runtime divisor input.
- Used wherever a slow derived clock or strobe is needed, for example serial interface bit clocks or LED/refresh timing.
- The output is fully registered, so it is glitch-free.

Parameters:
- WIDTH, 24, bit width of the divisor input and of the internal half-period counter.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- divisor  input  WIDTH  half-period length minus one, unsigned. Output frequency = f_clock / (2*(divisor+1)).
- output_clock  output  1  divided clock, registered, 50% duty cycle.
- rise_strobe  output  1  one-clock-cycle pulse, asserted in the cycle in which output_clock goes 0->1.

Behaviour:
- Reset (reset_n low, asynchronous):
  - counter = 0, output_clock = 0, rise_strobe = 0.
  - Outputs are held while reset is low.
  - Reset deasserting mid-period restarts the count from 0.
- Each rising clock edge (reset_n high):
  - If counter >= effective divisor: counter <= 0 and output_clock <= ~output_clock.
  - Otherwise: counter <= counter + 1 and output_clock is unchanged.
- Toggle timing: output_clock toggles every (divisor+1) clock edges.
  - divisor=0 -> f/2, toggling on every edge.
  - divisor=1 -> f/4.
  - divisor=2 -> f/6.
- Maximum divisor: 2^WIDTH-1 gives f/2^(WIDTH+1). The counter never exceeds the divisor, so it never wraps.
- rise_strobe:
  - Registered, asserted for exactly one cycle, coincident with the cycle in which output_clock first reads 1.
  - With divisor=0 it is high every other cycle.
- Live divisor change (default build):
  - The compare uses ">=", not "==".
  - If divisor drops below the current counter value, the output toggles on the next edge and the counter resets. It must never run through a full 2^WIDTH wrap.
  - A raised divisor extends the current half-period immediately.
- The divisor is treated as unsigned; there are no illegal values.
- No combinational path from any input to the outputs, apart from the reset clear.

Optional Feature:
- Macro: CLOCK_DIVIDER_SAFE_LOAD_EN.
- When defined:
  - divisor is captured into an internal shadow register only at a toggle point (counter >= shadow), and in the first cycle after reset deassertion.
  - The compare uses the shadow register, so every half-period already in progress completes with its original length.
  - The shadow register resets to 0.
- When undefined: the live divisor is compared directly, as described under Behaviour.

Decomposition:
- Package clock_divider_pkg holds:
  - the localparam for the default WIDTH (24);
  - a typedef divisor_t of logic [WIDTH-1:0].
- Single flat module; no sub-module is warranted. The counter, compare and toggle flop form one always_ff block, plus the optional shadow register.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, toggling clock -> output_clock=0 and rise_strobe=0 throughout. Assert reset_n=0 mid-period -> outputs clear immediately, without waiting for a clock edge.
- divisor=0, 12 edges -> output_clock toggles every edge (period 2 clocks); rise_strobe pulses on 6 of the cycles.
- divisor=1, then 2, then 3 (12-16 edges each) -> high/low phases of 2, 3 and 4 clocks respectively; duty cycle exactly 50%.
- divisor=5 set, then changed to 1 when counter=4 (default build) -> toggle on the next edge, then a steady f/4 output with no long stall.
- With CLOCK_DIVIDER_SAFE_LOAD_EN: the same change as above -> the current half-period still lasts 6 clocks, and subsequent half-periods last 2 clocks.
- divisor=24'hFFFFFF (short run, or WIDTH=4 with divisor=15) -> toggles every 16 edges at WIDTH=4; the counter never exceeds 15.
